// File: rtl/instr_decode_stage.sv
// -----------------------------------------------------------------------------
// instr_decode_stage
//   Registered, handshaked RV32I decode stage sitting between fetch and
//   execute. Splits the instruction into its fields, assembles the
//   sign-extended immediate for the I/S/B/U/J formats, classifies the format,
//   reports register usage and flags illegal encodings. The decoded bundle is
//   held in a one-entry output register with valid/ready flow control and flush.
//
// Parameters
//   XLEN  width of out_imm (32 or 64); the immediate is sign-extended to XLEN
//   PC_W  width of the PC carried with the instruction
//
// Ports
//   clk, rst_n (async, active low), flush
//   in_valid / in_ready / in_instr / in_pc      : upstream handshake + payload
//   out_valid / out_ready                       : downstream handshake
//   out_pc, out_opcode, out_rd, out_rs1, out_rs2,
//   out_funct3, out_funct7, out_imm, out_fmt,
//   out_rd_wr, out_rs1_used, out_rs2_used,
//   out_illegal                                 : registered decoded bundle
//
// Optional feature macro: DECODE_SKID_BUF_EN
//   Defined   : adds a one-entry skid buffer; in_ready becomes a register
//               output with no combinational path from out_ready.
//   Undefined : in_ready = !out_valid || out_ready.
// -----------------------------------------------------------------------------
module instr_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rd_wr,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            rd_wr;
    logic            rs1_used;
    logic            rs2_used;
    logic            illegal;
  } bundle_t;

  logic [6:0]         w_opcode;
  logic [2:0]         w_funct3;
  logic [6:0]         w_funct7;
  logic [4:0]         w_rd;
  logic [2:0]         w_fmt;
  logic signed [31:0] w_imm32;
  logic [6:0]         w_sh_up;
  logic               w_is_r, w_is_i, w_is_s, w_is_b, w_is_u, w_is_j;
  logic               w_fence, w_r_bad, w_sh_bad, w_b_bad, w_jalr_bad;
  logic               w_illegal;
  bundle_t            w_dec;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
  assign w_rd     = in_instr[11:7];

  // Opcode to instruction format classification.
  always_comb begin
    w_fmt = FMT_X;
    case (w_opcode)
      7'b0110011:                                          w_fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:                              w_fmt = FMT_I;
      7'b0100011:                                          w_fmt = FMT_S;
      7'b1100011:                                          w_fmt = FMT_B;
      7'b0110111, 7'b0010111:                              w_fmt = FMT_U;
      7'b1101111:                                          w_fmt = FMT_J;
      default:                                             w_fmt = FMT_X;
    endcase
  end

  // Immediate assembly; the sign bit is always instr[31].
  always_comb begin
    w_imm32 = 32'sd0;
    case (w_fmt)
      FMT_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   w_imm32 = {in_instr[31:12], 12'b0};
      FMT_J:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      default: w_imm32 = 32'sd0;
    endcase
  end

  assign w_is_r  = (w_fmt == FMT_R);
  assign w_is_i  = (w_fmt == FMT_I);
  assign w_is_s  = (w_fmt == FMT_S);
  assign w_is_b  = (w_fmt == FMT_B);
  assign w_is_u  = (w_fmt == FMT_U);
  assign w_is_j  = (w_fmt == FMT_J);
  assign w_fence = (w_opcode == OP_FENCE);

  // RV64 shamt is 6 bits wide, so only instr[31:26] are checked there; the
  // padded zero lets both widths compare against the same 7-bit patterns.
  assign w_sh_up = (XLEN == 64) ? {in_instr[31:26], 1'b0} : in_instr[31:25];

  assign w_r_bad = w_is_r &&
                   !((w_funct7 == 7'b0000000) ||
                     ((w_funct7 == 7'b0100000) &&
                      ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
  assign w_sh_bad = (w_opcode == OP_OPIMM) &&
                    ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)) &&
                    !((w_sh_up == 7'b0000000) ||
                      ((w_sh_up == 7'b0100000) && (w_funct3 == 3'b101)));
  assign w_b_bad    = w_is_b && ((w_funct3 == 3'b010) || (w_funct3 == 3'b011));
  assign w_jalr_bad = (w_opcode == OP_JALR) && (w_funct3 != 3'b000);

  assign w_illegal = (in_instr[1:0] != 2'b11) || (w_fmt == FMT_X) ||
                     w_r_bad || w_sh_bad || w_b_bad || w_jalr_bad;

  // Decoded bundle; usage flags are suppressed for illegal encodings so
  // execute never schedules register traffic for a trapping instruction.
  always_comb begin
    w_dec          = '0;
    w_dec.pc       = in_pc;
    w_dec.opcode   = w_opcode;
    w_dec.rd       = w_rd;
    w_dec.rs1      = in_instr[19:15];
    w_dec.rs2      = in_instr[24:20];
    w_dec.funct3   = w_funct3;
    w_dec.funct7   = w_funct7;
    w_dec.imm      = XLEN'(w_imm32);
    w_dec.fmt      = w_fmt;
    w_dec.illegal  = w_illegal;
    w_dec.rs1_used = !w_illegal && (w_is_r || w_is_i || w_is_s || w_is_b) && !w_fence;
    w_dec.rs2_used = !w_illegal && (w_is_r || w_is_s || w_is_b);
    // SYSTEM with funct3=0 (ECALL/EBREAK/xRET) never writes rd.
    w_dec.rd_wr    = !w_illegal && (w_is_r || w_is_i || w_is_u || w_is_j) &&
                     !w_fence && (w_rd != 5'd0) &&
                     !((w_opcode == OP_SYSTEM) && (w_funct3 == 3'b000));
  end

  bundle_t r_out;
  logic    r_valid;
  logic    w_xfer;

`ifdef DECODE_SKID_BUF_EN
  bundle_t r_skid;
  logic    r_skid_valid;
  logic    r_in_ready;
  logic    w_out_free;

  assign in_ready   = r_in_ready;
  assign w_out_free = !r_valid || out_ready;
  assign w_xfer     = in_valid && r_in_ready;

  // Output register plus skid entry; the skid drains first to keep order and
  // in_ready is registered as the complement of the next skid occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_out        <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_valid      <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_xfer) begin
        r_out   <= w_dec;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (w_xfer) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end
`else
  assign in_ready = !r_valid || out_ready;
  assign w_xfer   = in_valid && in_ready;

  // Output register: load on transfer, drain on downstream accept; flush wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out   <= w_dec;
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end
`endif

  assign out_valid    = r_valid;
  assign out_pc       = r_out.pc;
  assign out_opcode   = r_out.opcode;
  assign out_rd       = r_out.rd;
  assign out_rs1      = r_out.rs1;
  assign out_rs2      = r_out.rs2;
  assign out_funct3   = r_out.funct3;
  assign out_funct7   = r_out.funct7;
  assign out_imm      = r_out.imm;
  assign out_fmt      = r_out.fmt;
  assign out_rd_wr    = r_out.rd_wr;
  assign out_rs1_used = r_out.rs1_used;
  assign out_rs2_used = r_out.rs2_used;
  assign out_illegal  = r_out.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_decode_stage
//   Directed bench for instr_decode_stage: decode of hand-picked encodings,
//   backpressure, flush and mid-operation reset. Expected values are
//   hand-computed constants. Works for both builds (DECODE_SKID_BUF_EN).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_decode_stage;

  localparam int XLEN = 32;
  localparam int PC_W = 32;

  localparam logic [31:0] I_ADDI  = 32'hFFF00093; // addi x1,x0,-1
  localparam logic [31:0] I_SW    = 32'h0020A423; // sw x2,8(x1)
  localparam logic [31:0] I_BEQ   = 32'hFE000EE3; // beq x0,x0,-4
  localparam logic [31:0] I_JAL   = 32'h001000EF; // jal x1,+2048
  localparam logic [31:0] I_ZERO  = 32'h00000000;
  localparam logic [31:0] I_SRAI  = 32'h4000D093; // srai x1,x1,0
  localparam logic [31:0] I_SLLIB = 32'h40009093; // slli with funct7=0100000
  localparam logic [31:0] I_LUI   = 32'h123450B7; // lui x1,0x12345
  localparam logic [31:0] I_SUB   = 32'h402081B3; // sub x3,x1,x2
  localparam logic [31:0] I_FENCE = 32'h0FF0000F; // fence

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = 32'h0;
  logic [PC_W-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_rd_wr, out_rs1_used, out_rs2_used, out_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_rd_wr(out_rd_wr), .out_rs1_used(out_rs1_used),
    .out_rs2_used(out_rs2_used), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_dec(input string tag, input logic [PC_W-1:0] pc,
                         input logic [2:0] fmt, input logic [31:0] imm,
                         input logic rd_wr, input logic rs1u, input logic rs2u,
                         input logic ill);
    chk({tag, ".valid"},   64'(out_valid),    64'd1);
    chk({tag, ".pc"},      64'(out_pc),       64'(pc));
    chk({tag, ".fmt"},     64'(out_fmt),      64'(fmt));
    chk({tag, ".imm"},     64'(out_imm),      64'(imm));
    chk({tag, ".rd_wr"},   64'(out_rd_wr),    64'(rd_wr));
    chk({tag, ".rs1u"},    64'(out_rs1_used), 64'(rs1u));
    chk({tag, ".rs2u"},    64'(out_rs2_used), 64'(rs2u));
    chk({tag, ".illegal"}, 64'(out_illegal),  64'(ill));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 64'(out_valid),   64'd0);
    chk({tag, ".pc"},    64'(out_pc),      64'd0);
    chk({tag, ".imm"},   64'(out_imm),     64'd0);
    chk({tag, ".fmt"},   64'(out_fmt),     64'd0);
    chk({tag, ".rd"},    64'(out_rd),      64'd0);
    chk({tag, ".op"},    64'(out_opcode),  64'd0);
    chk({tag, ".rdwr"},  64'(out_rd_wr),   64'd0);
    chk({tag, ".rs1u"},  64'(out_rs1_used), 64'd0);
    chk({tag, ".ill"},   64'(out_illegal), 64'd0);
  endtask

  initial begin
    // Power-on reset.
    #12;
    chk_zero("rst");
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    step();

    // Decode of individual encodings, back to back with out_ready=1.
    send(I_ADDI, 32'h1000);
    chk_dec("addi", 32'h1000, 3'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("addi.rd", 64'(out_rd), 64'd1);
    send(I_SW, 32'h1004);
    chk_dec("sw", 32'h1004, 3'd2, 32'h00000008, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("sw.rs1", 64'(out_rs1), 64'd1);
    chk("sw.rs2", 64'(out_rs2), 64'd2);
    chk("sw.f3", 64'(out_funct3), 64'd2);
    send(I_BEQ, 32'h1008);
    chk_dec("beq", 32'h1008, 3'd3, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b1, 1'b0);
    send(I_JAL, 32'h100C);
    chk_dec("jal", 32'h100C, 3'd5, 32'h00000800, 1'b1, 1'b0, 1'b0, 1'b0);
    send(I_ZERO, 32'h1010);
    chk_dec("zero", 32'h1010, 3'd7, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1);
    send(I_SRAI, 32'h1014);
    chk_dec("srai", 32'h1014, 3'd1, 32'h00000400, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("srai.f7", 64'(out_funct7), 64'h20);
    send(I_SLLIB, 32'h1018);
    chk_dec("slli_bad", 32'h1018, 3'd1, 32'h00000400, 1'b0, 1'b0, 1'b0, 1'b1);
    send(I_LUI, 32'h101C);
    chk_dec("lui", 32'h101C, 3'd4, 32'h12345000, 1'b1, 1'b0, 1'b0, 1'b0);
    send(I_SUB, 32'h1020);
    chk_dec("sub", 32'h1020, 3'd0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("sub.rd", 64'(out_rd), 64'd3);
    send(I_FENCE, 32'h1024);
    chk_dec("fence", 32'h1024, 3'd1, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("drain.valid", 64'(out_valid), 64'd0);

    // Backpressure: two instructions offered while the output stalls.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = I_ADDI;
    in_pc     = 32'h200;
    step();
    in_instr  = I_SW;
    in_pc     = 32'h204;
`ifdef DECODE_SKID_BUF_EN
    #1;
    chk("bp.rdy_skid_free", 64'(in_ready), 64'd1);
    step();
    chk("bp.hold1", 64'(out_pc), 64'h200);
    in_instr = I_BEQ;
    in_pc    = 32'h208;
    #1;
    chk("bp.rdy_full", 64'(in_ready), 64'd0);
    step();
    chk("bp.hold2", 64'(out_pc), 64'h200);
    chk("bp.rdy_full2", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    step();
    chk("bp.hold3", 64'(out_pc), 64'h200);
    chk("bp.hold3.imm", 64'(out_imm), 64'hFFFFFFFF);
    chk("bp.hold3.valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp.second.pc", 64'(out_pc), 64'h204);
    chk("bp.second.fmt", 64'(out_fmt), 64'd2);
    chk("bp.second.valid", 64'(out_valid), 64'd1);
    step();
    chk("bp.done.valid", 64'(out_valid), 64'd0);
    chk("bp.done.rdy", 64'(in_ready), 64'd1);
`else
    #1;
    chk("bp.rdy0", 64'(in_ready), 64'd0);
    step();
    chk("bp.hold1", 64'(out_pc), 64'h200);
    chk("bp.rdy1", 64'(in_ready), 64'd0);
    step();
    chk("bp.hold2", 64'(out_pc), 64'h200);
    step();
    chk("bp.hold3", 64'(out_pc), 64'h200);
    chk("bp.hold3.imm", 64'(out_imm), 64'hFFFFFFFF);
    chk("bp.hold3.valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    #1;
    chk("bp.rdy_release", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp.second.pc", 64'(out_pc), 64'h204);
    chk("bp.second.fmt", 64'(out_fmt), 64'd2);
    chk("bp.second.valid", 64'(out_valid), 64'd1);
    step();
    chk("bp.done.valid", 64'(out_valid), 64'd0);
`endif

    // Flush with a held bundle and a new input in the same cycle.
    out_ready = 1'b0;
    send(I_ADDI, 32'h300);
    chk("fl.pre.valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = I_SW;
    in_pc     = 32'h304;
    flush     = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl.valid0", 64'(out_valid), 64'd0);
    step();
    chk("fl.valid1", 64'(out_valid), 64'd0);
    step();
    chk("fl.valid2", 64'(out_valid), 64'd0);

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    send(I_JAL, 32'h400);
    chk("mr.pre.valid", 64'(out_valid), 64'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk_zero("mr");
    rst_n = 1'b1;
    #1;
    chk("mr.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    chk("mr.post.valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
